// File: rtl/anc_frame_scheduler.sv
// Per-frame sequencer for the ANC datapath: owns the shared I2S frame counter,
// gathers one ref/err sample pair per frame, fires the filter and streams its output.
module anc_frame_scheduler #(
    parameter int EOF_COUNT = 455,
    parameter int OVR_W     = 16
) (
    input  logic             axis_clk,
    input  logic             axis_reset,
    input  logic             enable,
    output logic [8:0]       count,
    input  logic [31:0]      ref_data,
    input  logic             ref_valid,
    input  logic             ref_last,
    output logic             ref_ready,
    input  logic [31:0]      err_data,
    input  logic             err_valid,
    input  logic             err_last,
    output logic             err_ready,
    output logic [23:0]      x_sample,
    output logic [23:0]      e_sample,
    output logic             sample_strobe,
    input  logic             filt_done,
    input  logic [23:0]      filt_y,
    output logic [31:0]      tx_data,
    output logic             tx_valid,
    output logic             tx_last,
    input  logic             tx_ready,
    output logic             overrun,
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam logic [8:0] EOF_CNT  = 9'(EOF_COUNT);
    localparam logic [8:0] LAST_CNT = 9'd511;

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_COMPUTE} main_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_L, TX_R} tx_state_t;

    main_state_t      state_reg, state_next;
    tx_state_t        tx_state_reg, tx_state_next;
    logic [8:0]       count_reg, count_next;
    logic             got_ref_reg, got_ref_next;
    logic             got_err_reg, got_err_next;
    logic [23:0]      x_sample_reg, x_sample_next;
    logic [23:0]      e_sample_reg, e_sample_next;
    logic [23:0]      y_reg, y_next;
    logic             overrun_reg, overrun_next;
    logic [OVR_W-1:0] overrun_cnt_reg, overrun_cnt_next;
    logic [31:0]      tx_data_reg, tx_data_next;

    // Only the 24-bit sample field of each mic word is used.
    logic unused_upper_bits;
    assign unused_upper_bits = ^{ref_data[31:24], err_data[31:24]};

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            count_reg       <= '0;
            state_reg       <= ST_IDLE;
            tx_state_reg    <= TX_IDLE;
            got_ref_reg     <= 1'b0;
            got_err_reg     <= 1'b0;
            x_sample_reg    <= '0;
            e_sample_reg    <= '0;
            y_reg           <= '0;
            overrun_reg     <= 1'b0;
            overrun_cnt_reg <= '0;
            tx_data_reg     <= '0;
        end else begin
            count_reg       <= count_next;
            state_reg       <= state_next;
            tx_state_reg    <= tx_state_next;
            got_ref_reg     <= got_ref_next;
            got_err_reg     <= got_err_next;
            x_sample_reg    <= x_sample_next;
            e_sample_reg    <= e_sample_next;
            y_reg           <= y_next;
            overrun_reg     <= overrun_next;
            overrun_cnt_reg <= overrun_cnt_next;
            tx_data_reg     <= tx_data_next;
        end
    end

    // The I2S clocks depend on this counter, so it never stops.
    assign count_next = count_reg + 9'd1;

    always_comb begin
        state_next       = state_reg;
        got_ref_next     = got_ref_reg;
        got_err_next     = got_err_reg;
        x_sample_next    = x_sample_reg;
        e_sample_next    = e_sample_reg;
        y_next           = y_reg;
        overrun_next     = overrun_reg;
        overrun_cnt_next = overrun_cnt_reg;
        ref_ready        = 1'b0;
        err_ready        = 1'b0;
        sample_strobe    = 1'b0;

        // Ready is gated by enable so no beat is consumed in a cycle that is being muted.
        if (!enable) begin
            state_next   = ST_IDLE;
            got_ref_next = 1'b0;
            got_err_next = 1'b0;
            y_next       = '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: state_next = ST_COLLECT;
                ST_COLLECT: begin
                    ref_ready = !got_ref_reg;
                    err_ready = !got_err_reg;
                    if (got_ref_reg && got_err_reg) begin
                        sample_strobe = 1'b1;
                        got_ref_next  = 1'b0;
                        got_err_next  = 1'b0;
                        state_next    = ST_COMPUTE;
                    end
                    if (ref_ready && ref_valid && ref_last) begin
                        x_sample_next = ref_data[23:0];
                        got_ref_next  = 1'b1;
                    end
                    if (err_ready && err_valid && err_last) begin
                        e_sample_next = err_data[23:0];
                        got_err_next  = 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    // A completion in the deadline cycle still counts as on time.
                    if (filt_done) begin
                        y_next     = filt_y;
                        state_next = ST_COLLECT;
                    end else if (count_reg == EOF_CNT) begin
                        overrun_next = 1'b1;
                        if (overrun_cnt_reg != '1)
                            overrun_cnt_next = overrun_cnt_reg + OVR_W'(1);
                        state_next = ST_COLLECT;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_data_next  = tx_data_reg;
        unique case (tx_state_reg)
            TX_IDLE: begin
                if (count_reg == EOF_CNT) begin
                    tx_state_next = TX_L;
                    tx_data_next  = {{8{y_reg[23]}}, y_reg};
                end
            end
            TX_L: if (tx_ready) tx_state_next = TX_R;
            TX_R: begin
                if (tx_ready) begin
                    tx_state_next = TX_IDLE;
                    tx_data_next  = '0;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
        // An unfinished packet never spills into the next frame.
        if (count_reg == LAST_CNT && tx_state_reg != TX_IDLE) begin
            tx_state_next = TX_IDLE;
            tx_data_next  = '0;
        end
    end

    assign count       = count_reg;
    assign x_sample    = x_sample_reg;
    assign e_sample    = e_sample_reg;
    assign tx_data     = tx_data_reg;
    assign tx_valid    = (tx_state_reg != TX_IDLE);
    assign tx_last     = (tx_state_reg == TX_R);
    assign overrun     = overrun_reg;
    assign overrun_cnt = overrun_cnt_reg;

endmodule

// File: tb/tb_anc_frame_scheduler.sv
// Bench for anc_frame_scheduler: directed frame scenarios then random traffic,
// all outputs checked every cycle against a frame-level behavioural model.
module tb_anc_frame_scheduler;

    localparam int EOF = 455;
    localparam int M_IDLE = 0, M_COLLECT = 1, M_COMPUTE = 2;

    logic        axis_clk = 1'b0;
    logic        axis_reset, enable;
    logic [8:0]  count;
    logic [31:0] ref_data, err_data, tx_data;
    logic        ref_valid, ref_last, ref_ready;
    logic        err_valid, err_last, err_ready;
    logic [23:0] x_sample, e_sample, filt_y;
    logic        sample_strobe, filt_done;
    logic        tx_valid, tx_last, tx_ready, overrun;
    logic [15:0] overrun_cnt;

    always #5 axis_clk = ~axis_clk;

    anc_frame_scheduler #(.EOF_COUNT(EOF), .OVR_W(16)) dut (
        .axis_clk(axis_clk), .axis_reset(axis_reset), .enable(enable), .count(count),
        .ref_data(ref_data), .ref_valid(ref_valid), .ref_last(ref_last), .ref_ready(ref_ready),
        .err_data(err_data), .err_valid(err_valid), .err_last(err_last), .err_ready(err_ready),
        .x_sample(x_sample), .e_sample(e_sample), .sample_strobe(sample_strobe),
        .filt_done(filt_done), .filt_y(filt_y),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .overrun(overrun), .overrun_cnt(overrun_cnt)
    );

    int n_vec = 0, n_err = 0;

    // Model: frame position, loop phase, captured samples, beats left in the TX window.
    int          m_cnt, m_mode, m_beats;
    logic        m_gx, m_ge, m_ovr;
    logic [23:0] m_x, m_e, m_y;
    logic [15:0] m_ovrc;
    logic [31:0] m_word;
    logic        ref_hs, err_hs, stb_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_mode = M_IDLE; m_beats = 0;
        m_gx = 0; m_ge = 0; m_ovr = 0; m_ovrc = '0;
        m_x = '0; m_e = '0; m_y = '0; m_word = '0;
    endtask

    task automatic step();
        logic e_rr, e_er, e_stb;
        int n_cnt, n_mode, n_beats;
        logic n_gx, n_ge, n_ovr;
        logic [23:0] n_x, n_e, n_y;
        logic [15:0] n_ovrc;
        logic [31:0] n_word;
        @(negedge axis_clk);
        e_rr  = enable && m_mode == M_COLLECT && !m_gx;
        e_er  = enable && m_mode == M_COLLECT && !m_ge;
        e_stb = enable && m_mode == M_COLLECT && m_gx && m_ge;
        chk("count", 32'(count), 32'(m_cnt));
        chk("ref_ready", 32'(ref_ready), 32'(e_rr));
        chk("err_ready", 32'(err_ready), 32'(e_er));
        chk("sample_strobe", 32'(sample_strobe), 32'(e_stb));
        chk("x_sample", 32'(x_sample), 32'(m_x));
        chk("e_sample", 32'(e_sample), 32'(m_e));
        chk("tx_valid", 32'(tx_valid), 32'(m_beats > 0));
        chk("tx_last", 32'(tx_last), 32'(m_beats == 1));
        chk("tx_data", tx_data, (m_beats > 0) ? m_word : 32'd0);
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovrc));
        ref_hs = e_rr && ref_valid;
        err_hs = e_er && err_valid;
        stb_seen = e_stb;
        if (m_beats == 1 && tx_ready && m_cnt != 511)
            $display("tx packet done at count %0d data %08h", m_cnt, m_word);

        n_cnt = (m_cnt + 1) % 512;
        n_beats = m_beats; n_word = m_word;
        if (m_beats > 0 && tx_ready) n_beats = m_beats - 1;
        if (m_cnt == 511) n_beats = 0;
        if (m_cnt == EOF) begin n_beats = 2; n_word = {{8{m_y[23]}}, m_y}; end

        n_mode = m_mode; n_gx = m_gx; n_ge = m_ge; n_x = m_x; n_e = m_e;
        n_y = m_y; n_ovr = m_ovr; n_ovrc = m_ovrc;
        if (!enable) begin
            n_mode = M_IDLE; n_gx = 0; n_ge = 0; n_y = '0;
        end else if (m_mode == M_IDLE) begin
            n_mode = M_COLLECT;
        end else if (m_mode == M_COLLECT) begin
            if (m_gx && m_ge) begin
                n_mode = M_COMPUTE; n_gx = 0; n_ge = 0;
            end else begin
                if (ref_hs && ref_last) begin n_x = ref_data[23:0]; n_gx = 1; end
                if (err_hs && err_last) begin n_e = err_data[23:0]; n_ge = 1; end
            end
        end else begin
            if (filt_done) begin
                n_y = filt_y; n_mode = M_COLLECT;
            end else if (m_cnt == EOF) begin
                n_ovr = 1; n_mode = M_COLLECT;
                if (m_ovrc != 16'hFFFF) n_ovrc = m_ovrc + 16'd1;
            end
        end
        @(posedge axis_clk);
        #1;
        if (axis_reset) model_reset();
        else begin
            m_cnt = n_cnt; m_mode = n_mode; m_beats = n_beats; m_word = n_word;
            m_gx = n_gx; m_ge = n_ge; m_x = n_x; m_e = n_e; m_y = n_y;
            m_ovr = n_ovr; m_ovrc = n_ovrc;
        end
    endtask

    task automatic run_to(input int c);
        int guard = 0;
        while (m_cnt != c && guard < 1100) begin
            step();
            guard++;
        end
        if (m_cnt != c) begin
            n_vec++; n_err++;
            $display("FAIL run_to: count %0d, required %0d", m_cnt, c);
        end
    endtask

    task automatic send_pair(input logic [31:0] rd, input logic [31:0] ed);
        ref_valid = 1; err_valid = 1; ref_data = rd; err_data = ed;
        ref_last = 0; err_last = 0;
        step();
        ref_last = 1; err_last = 1;
        step();
        ref_valid = 0; err_valid = 0; ref_last = 0; err_last = 0;
    endtask

    initial begin
        int   fd_timer = 0;
        logic r_beat = 1'b1, e_beat = 1'b0, stall = 1'b0;
        axis_reset = 1; enable = 0; ref_data = '0; err_data = '0;
        ref_valid = 0; ref_last = 0; err_valid = 0; err_last = 0;
        filt_done = 0; filt_y = '0; tx_ready = 1;
        model_reset();
        @(posedge axis_clk); #1;
        repeat (3) step();
        axis_reset = 0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);

        // Idle loop still sends a zero packet each frame.
        run_to(456);
        chk("t1_valid", 32'(tx_valid), 32'd1);
        chk("t1_data", tx_data, 32'd0);
        step();
        chk("t1_last", 32'(tx_last), 32'd1);
        step();
        chk("t1_done", 32'(tx_valid), 32'd0);

        // Ref packet at 456, err packet three cycles later.
        enable = 1;
        run_to(456);
        ref_valid = 1; ref_data = 32'h000ABCDE; ref_last = 0; step();
        ref_last = 1; step();
        ref_valid = 0; ref_last = 0; step();
        err_valid = 1; err_data = 32'h00FFFFFF; err_last = 0; step();
        err_last = 1; step();
        err_valid = 0; err_last = 0;
        chk("t2_strobe", 32'(sample_strobe), 32'd1);
        chk("t2_x", 32'(x_sample), 32'h000ABCDE);
        chk("t2_e", 32'(e_sample), 32'h00FFFFFF);
        step();
        chk("t2_strobe_off", 32'(sample_strobe), 32'd0);

        filt_y = 24'h800001; filt_done = 1; step();
        filt_done = 0;
        run_to(456);
        chk("t3_beat1", tx_data, 32'hFF800001);
        chk("t3_last1", 32'(tx_last), 32'd0);
        step();
        chk("t3_beat2", tx_data, 32'hFF800001);
        chk("t3_last2", 32'(tx_last), 32'd1);

        // Missed deadline: old y retransmitted, loop keeps accepting.
        run_to(10);
        send_pair(32'h00123456, 32'h00654321);
        run_to(456);
        chk("t4_overrun", 32'(overrun), 32'd1);
        chk("t4_ovr_cnt", 32'(overrun_cnt), 32'd1);
        chk("t4_old_y", tx_data, 32'hFF800001);
        run_to(470);
        chk("t4_ready", 32'(ref_ready), 32'd1);
        send_pair(32'h00111111, 32'h00222222);
        step();
        filt_y = 24'h000123; filt_done = 1; step();
        filt_done = 0;

        // Stalled speaker: packet dropped at wrap.
        run_to(450);
        tx_ready = 0;
        run_to(511);
        chk("t5_stalled", 32'(tx_valid), 32'd1);
        step();
        chk("t5_drop", 32'(tx_valid), 32'd0);
        chk("t5_no_ovr", 32'(overrun_cnt), 32'd1);
        tx_ready = 1;
        run_to(457);
        chk("t5_resume", tx_data, 32'h00000123);

        // Mute mid-packet, then reset during the second TX beat.
        run_to(20);
        ref_valid = 1; ref_data = 32'h00AAAAAA; ref_last = 0; step();
        ref_valid = 0; enable = 0; step();
        chk("t6_ready", 32'(ref_ready), 32'd0);
        run_to(456);
        chk("t6_y_zero", tx_data, 32'd0);
        step();
        axis_reset = 1; step();
        axis_reset = 0; enable = 1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_tx", 32'(tx_valid), 32'd0);
        chk("t6_ovr", 32'(overrun_cnt), 32'd0);

        for (int i = 0; i < 24000; i++) begin
            if (!ref_valid && $urandom_range(3) == 0) begin
                ref_valid = 1; ref_data = $urandom; ref_last = r_beat;
            end
            if (!err_valid && $urandom_range(3) == 0) begin
                err_valid = 1; err_data = $urandom; err_last = e_beat;
            end
            filt_done = 0;
            if (fd_timer == 1 || $urandom_range(127) == 0) begin
                filt_done = 1; filt_y = 24'($urandom);
            end
            if (fd_timer > 0) fd_timer--;
            if (m_cnt == 0) stall = ($urandom_range(5) == 0);
            tx_ready = !stall && ($urandom_range(3) != 0);
            if (enable && $urandom_range(1499) == 0) enable = 0;
            else if (!enable && $urandom_range(15) == 0) enable = 1;
            axis_reset = ($urandom_range(6999) == 0);
            step();
            if (ref_hs) begin ref_valid = 0; r_beat = ~r_beat; end
            if (err_hs) begin err_valid = 0; e_beat = ~e_beat; end
            if (stb_seen) fd_timer = $urandom_range(1, 600);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
